// File: rtl/cpu_bus_initiator_if.sv
// rtl/cpu_bus_initiator_if.sv - request/response handshake and 386-style bus control signals
interface cpu_bus_initiator_if;
    logic        req_valid;
    logic        req_ready;
    logic [21:0] req_addr;
    logic        req_wr;
    logic        req_mio;
    logic [3:0]  req_mask;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [23:1] bus_a;
    logic        bus_ads_n;
    logic        bus_bhe_n;
    logic        bus_ble_n;
    logic        bus_wr;
    logic        bus_mio;
    logic        bus_dc;
    logic        bus_ready_n;

    modport master (
        input  req_valid, req_addr, req_wr, req_mio, req_mask, req_wdata, bus_ready_n,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_a, bus_ads_n, bus_bhe_n, bus_ble_n, bus_wr, bus_mio, bus_dc
    );

    modport slave (
        output req_valid, req_addr, req_wr, req_mio, req_mask, req_wdata, bus_ready_n,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_a, bus_ads_n, bus_bhe_n, bus_ble_n, bus_wr, bus_mio, bus_dc
    );
endinterface

// File: rtl/cpu_bus_initiator.sv
// rtl/cpu_bus_initiator.sv - splits 32-bit requests into one or two 16-bit 386-style bus cycles
module cpu_bus_initiator #(
    parameter int READY_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    cpu_bus_initiator_if.master bif,
    inout  wire  [15:0]         bus_d
);
    localparam int CW = (READY_TIMEOUT < 2) ? 1 : $clog2(READY_TIMEOUT);

    typedef enum logic [1:0] {IDLE, ADDR, WAIT} state_t;

    state_t        state;
    logic [3:0]    mask_q;
    logic [31:0]   wdata_q;
    logic          high_q;
    logic [CW-1:0] wait_cnt;
    logic          drive_en;
    logic [15:0]   dout;
    logic          lo_empty;
    logic          hi_pending;

    // A request with no low-half bytes starts directly on the high half.
    assign lo_empty      = (bif.req_mask[1:0] == 2'b00);
    assign hi_pending    = !high_q && (mask_q[3:2] != 2'b00);
    assign bif.req_ready = (state == IDLE);
    assign bif.bus_dc    = 1'b1;
    assign bus_d         = drive_en ? dout : 16'hzzzz;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            mask_q        <= '0;
            wdata_q       <= '0;
            high_q        <= 1'b0;
            wait_cnt      <= '0;
            drive_en      <= 1'b0;
            dout          <= '0;
            bif.bus_a     <= '0;
            bif.bus_ads_n <= 1'b1;
            bif.bus_bhe_n <= 1'b1;
            bif.bus_ble_n <= 1'b1;
            bif.bus_wr    <= 1'b0;
            bif.bus_mio   <= 1'b0;
            bif.rsp_valid <= 1'b0;
            bif.rsp_rdata <= '0;
            bif.rsp_err   <= 1'b0;
        end else begin
            bif.rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bif.req_valid) begin
                        mask_q        <= bif.req_mask;
                        wdata_q       <= bif.req_wdata;
                        bif.rsp_rdata <= '0;
                        bif.rsp_err   <= 1'b0;
                        if (bif.req_mask == 4'h0) begin
                            bif.rsp_valid <= 1'b1;
                        end else begin
                            state         <= ADDR;
                            high_q        <= lo_empty;
                            bif.bus_a     <= {bif.req_addr, lo_empty};
                            bif.bus_ads_n <= 1'b0;
                            bif.bus_ble_n <= lo_empty ? ~bif.req_mask[2] : ~bif.req_mask[0];
                            bif.bus_bhe_n <= lo_empty ? ~bif.req_mask[3] : ~bif.req_mask[1];
                            bif.bus_wr    <= bif.req_wr;
                            bif.bus_mio   <= bif.req_mio;
                            drive_en      <= bif.req_wr;
                            dout          <= lo_empty ? bif.req_wdata[31:16] : bif.req_wdata[15:0];
                        end
                    end
                end
                ADDR: begin
                    state         <= WAIT;
                    bif.bus_ads_n <= 1'b1;
                    wait_cnt      <= '0;
                end
                WAIT: begin
                    if (!bif.bus_ready_n) begin
                        if (!bif.bus_wr) begin
                            if (high_q) bif.rsp_rdata[31:16] <= bus_d;
                            else        bif.rsp_rdata[15:0]  <= bus_d;
                        end
                        // Chain straight into the high half; write drive stays on across the turn.
                        if (hi_pending) begin
                            state         <= ADDR;
                            high_q        <= 1'b1;
                            bif.bus_a[1]  <= 1'b1;
                            bif.bus_ads_n <= 1'b0;
                            bif.bus_ble_n <= ~mask_q[2];
                            bif.bus_bhe_n <= ~mask_q[3];
                            dout          <= wdata_q[31:16];
                        end else begin
                            state         <= IDLE;
                            bif.rsp_valid <= 1'b1;
                            bif.rsp_err   <= 1'b0;
                            bif.bus_ble_n <= 1'b1;
                            bif.bus_bhe_n <= 1'b1;
                            drive_en      <= 1'b0;
                        end
                    end else if (wait_cnt == CW'(READY_TIMEOUT - 1)) begin
                        state         <= IDLE;
                        bif.rsp_valid <= 1'b1;
                        bif.rsp_err   <= 1'b1;
                        bif.bus_ble_n <= 1'b1;
                        bif.bus_bhe_n <= 1'b1;
                        drive_en      <= 1'b0;
                    end else begin
                        wait_cnt <= wait_cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/cpu_bus_initiator.md
CPU_BUS_INITIATOR -- requirements
Module: cpu_bus_initiator

Converts internal 32-bit requests into one or two 386-style 16-bit bus cycles. This is the initiator end of the bus that busmaster responds to.

Interface
REQ-001 SHALL have parameter READY_TIMEOUT, default 255: clocks waited in WAIT for bus_ready_n before aborting.
REQ-002 SHALL have ports:
- clk  in  1  sole clock; all logic on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  accept; high only in IDLE.
- req_addr  in  22  word address [23:2].
- req_wr  in  1  1 = write, 0 = read.
- req_mio  in  1  1 = memory, 0 = IO.
- req_mask  in  4  byte enables; bit n = byte n.
- req_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  32  assembled read data.
- rsp_err  out  1  timeout flag; qualified by rsp_valid.
- bus_a  out  23  address [23:1].
- bus_d  inout  16  data bus.
- bus_ads_n  out  1  address strobe.
- bus_bhe_n  out  1  high byte enable.
- bus_ble_n  out  1  low byte enable.
- bus_wr  out  1  write/read.
- bus_mio  out  1  memory/IO.
- bus_dc  out  1  constant 1.
- bus_ready_n  in  1  cycle-complete input from the responder.

Function
REQ-003 States SHALL be IDLE, ADDR, WAIT.
- A request is accepted when req_valid and req_ready are both high.
- On acceptance, the module latches addr, wr, mio, mask and wdata.
REQ-004 Halves:
- The low half is needed if mask[1:0] != 0; the high half is needed if mask[3:2] != 0.
- The low half SHALL always be issued before the high half.
REQ-005 If an accepted request has mask = 0, there SHALL be no bus cycle: next cycle rsp_valid = 1, rsp_rdata = 0, rsp_err = 0.
REQ-006 IDLE -> ADDR on acceptance with nonzero mask. ADDR SHALL last exactly one clock.
REQ-007 In ADDR:
- bus_ads_n = 0.
- bus_a[23:2] = latched addr; bus_a[1] = 0 for the low half, 1 for the high half.
- bus_ble_n = ~mask[0] (low half) or ~mask[2] (high half).
- bus_bhe_n = ~mask[1] (low half) or ~mask[3] (high half).
- bus_wr and bus_mio = latched values.
REQ-008 ADDR -> WAIT unconditionally. Address, byte enables, wr and mio SHALL stay stable through WAIT; bus_ads_n = 1 in WAIT.
REQ-009 For writes, bus_d SHALL be driven from ADDR through the final WAIT clock of that half. Low half drives wdata[15:0]; high half drives wdata[31:16].
- For reads, bus_d SHALL be high-Z at all times.
REQ-010 In WAIT, bus_ready_n is sampled every rising edge. When it is sampled low:
- Read: bus_d is captured into rsp_rdata[15:0] (low half) or [31:16] (high half).
- If the high half is still pending: next state ADDR for the high half, with no idle clock between.
- Otherwise: next state IDLE, rsp_valid = 1 for one clock, rsp_err = 0.
REQ-011 rsp_rdata bytes of halves not transferred SHALL be 0. rsp_rdata SHALL be cleared on acceptance and held after rsp_valid until the next acceptance.
REQ-012 A wait counter SHALL clear on entering WAIT.
- If READY_TIMEOUT clocks elapse with bus_ready_n high: go to IDLE, rsp_valid = 1, rsp_err = 1.
- Any remaining half SHALL be skipped.
- Already-captured read data SHALL be kept.
REQ-013 In the rsp_valid cycle the state is IDLE, so req_ready = 1 and a new request SHALL be acceptable in that same cycle.
REQ-014 Minimum latency from acceptance to rsp_valid:
- Single half: 3 clocks.
- Two halves: 5 clocks.
REQ-015 bus_ready_n SHALL be ignored outside WAIT. req_valid SHALL be ignored outside IDLE.
REQ-016 Outside ADDR/WAIT, bus outputs SHALL hold their idle values: ads_n = 1, bhe_n = 1, ble_n = 1, bus_d high-Z. bus_a, bus_wr and bus_mio hold their last values.

Reset
REQ-017 While rst_n = 0:
- state = IDLE; bus_ads_n = 1, bus_bhe_n = 1, bus_ble_n = 1.
- bus_a = 0, bus_wr = 0, bus_mio = 0, bus_d high-Z, bus_dc = 1.
- rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, wait counter = 0.
REQ-018 Reset asserted mid-transfer SHALL release the bus immediately (asynchronously) and SHALL produce no rsp_valid for the aborted request. After release, the module SHALL accept a new request on the first edge.

Verification
REQ-019 Word read:
- Stimulus: addr 0x3C00 (byte 0xF000), mask 0xF, responder returns 0x1234 (low half) then 0xABCD (high half), each with ready on the first WAIT clock.
- Response: two ADS pulses with bus_a[1] = 0 then 1; rsp_rdata = 0xABCD1234 at clock 5.
REQ-020 High-byte write:
- Stimulus: mask 0x8, wdata 0xAA000000.
- Response: a single cycle with bus_a[1] = 1, bhe_n = 0, ble_n = 1, bus_d = 0xAA00; rsp_err = 0.
REQ-021 Timeout:
- Stimulus: READY_TIMEOUT = 4, bus_ready_n held high, mask 0xF.
- Response: rsp_valid with rsp_err = 1 after 4 WAIT clocks; no second ADS.
REQ-022 Mask 0:
- Response: no ADS; rsp_valid on the next clock with rdata = 0.
REQ-023 Reset in WAIT of a write:
- Response: bus_d goes high-Z and ads/bhe/ble go high immediately; no rsp_valid.
- A new read issued after reset completes normally.
REQ-024 Back-to-back:
- Stimulus: second request presented in the rsp_valid cycle.
- Response: the second request is accepted in that cycle; its ADS follows on the next clock.
